// File: rtl/spi_slave_rx.sv
// SPI responder: oversampled scl/cs/mosi, LSB-first byte in on mosi and out on miso.
// Define SPI_SLAVE_OVR_EN to add the rx_ack input and the sticky rx_ovr overrun flag.
module spi_slave_rx #(
    parameter logic TRIG     = 1'b1,
    parameter int   SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
`ifdef SPI_SLAVE_OVR_EN
    input  logic       rx_ack,
    output logic       rx_ovr,
`endif
    output logic       busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] FILL = 2'(SYNC_STG);

    state_t state, state_nxt;

    logic [SYNC_STG-1:0] scl_sync, cs_sync, mosi_sync;
    logic       scl_s, cs_s, mosi_s;
    logic       scl_prev, cs_prev;
    logic [1:0] fill_cnt;
    logic       armed;
    logic       sample_edge, cs_fall, cs_rise;
    logic       do_start, do_sample, do_abort;
    logic [2:0] bit_cnt, bit_nxt;
    logic [7:0] shift_tx, shift_rx, tx_hold;
    logic       frame_done;

    assign scl_s = scl_sync[SYNC_STG-1];
    assign cs_s  = cs_sync[SYNC_STG-1];
    assign mosi_s = mosi_sync[SYNC_STG-1];
    assign busy  = ~cs_s;

    // NOTE: every clocked register uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync  <= {SYNC_STG{~TRIG}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            scl_prev  <= ~TRIG;
            cs_prev   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STG-2:0], scl};
            cs_sync   <= {cs_sync[SYNC_STG-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], mosi};
            scl_prev  <= scl_s;
            cs_prev   <= cs_s;
        end
    end

    // A frame may only start once cs has really been seen high after the chain refilled,
    // so a reset in the middle of a frame cannot restart on the forced-high reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != FILL)
                fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == FILL && cs_s)
                armed <= 1'b1;
        end
    end

    assign sample_edge = (scl_prev == TRIG) && (scl_s != TRIG);
    assign cs_fall     = armed && cs_prev && !cs_s;
    assign cs_rise     = cs_s && !cs_prev;
    assign bit_nxt     = bit_cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_sample = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                    do_start  = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    do_abort  = 1'b1;
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_tx   <= '0;
            shift_rx   <= '0;
            tx_hold    <= '0;
            miso       <= 1'b0;
            frame_done <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            if (tx_load)
                tx_hold <= tx_data;

            frame_done <= 1'b0;
            rx_valid   <= frame_done;
            if (frame_done)
                rx_data <= shift_rx;

            if (do_abort) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
            end else if (do_start) begin
                shift_tx <= tx_hold;
                miso     <= tx_hold[0];
                bit_cnt  <= '0;
            end else if (do_sample) begin
                shift_rx[bit_cnt] <= mosi_s;
                bit_cnt           <= bit_nxt;
                if (bit_cnt == 3'd7) begin
                    // Reload immediately so a following frame under the same cs-low is ready.
                    frame_done <= 1'b1;
                    shift_tx   <= tx_hold;
                    miso       <= tx_hold[0];
                end else begin
                    miso <= shift_tx[bit_nxt];
                end
            end
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    logic pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            rx_ovr  <= 1'b0;
        end else if (frame_done) begin
            pending <= 1'b1;
            if (pending)
                rx_ovr <= 1'b1;
        end else if (rx_ack) begin
            pending <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a TRIG=1 and a TRIG=0 instance share one master.
// Overrun checks compile in when SPI_SLAVE_OVR_EN is defined.
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int SYNC_STG = 2;
    localparam int HALF     = 6;

    logic       clk = 1'b0;
    logic       rst, scl, cs, mosi, tx_load;
    logic [7:0] tx_data;
    logic       scl_n;
    logic       miso1, miso0, rx_valid1, rx_valid0, busy1, busy0;
    logic [7:0] rx_data1, rx_data0;
`ifdef SPI_SLAVE_OVR_EN
    logic       rx_ack;
    logic       rx_ovr1, rx_ovr0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q0[$];
    logic [7:0] got1, got0;

    // A trig=0 master is the same waveform with scl inverted.
    assign scl_n = ~scl;

    always #5 clk = ~clk;

    spi_slave_rx #(.TRIG(1'b1), .SYNC_STG(SYNC_STG)) dut1 (
        .clk(clk), .rst(rst), .scl(scl), .cs(cs), .mosi(mosi), .miso(miso1),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data1), .rx_valid(rx_valid1),
`ifdef SPI_SLAVE_OVR_EN
        .rx_ack(rx_ack), .rx_ovr(rx_ovr1),
`endif
        .busy(busy1)
    );

    spi_slave_rx #(.TRIG(1'b0), .SYNC_STG(SYNC_STG)) dut0 (
        .clk(clk), .rst(rst), .scl(scl_n), .cs(cs), .mosi(mosi), .miso(miso0),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data0), .rx_valid(rx_valid0),
`ifdef SPI_SLAVE_OVR_EN
        .rx_ack(rx_ack), .rx_ovr(rx_ovr0),
`endif
        .busy(busy0)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid1) begin
                if (exp_q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx1_unexpected: got rx_valid with %h, expected none", rx_data1);
                end else check("rx1_data", rx_data1, exp_q1.pop_front());
            end
            if (rx_valid0) begin
                if (exp_q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx0_unexpected: got rx_valid with %h, expected none", rx_data0);
                end else check("rx0_data", rx_data0, exp_q0.pop_front());
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();  cs = 1'b0; wait_clk(8); endtask
    task automatic cs_high(); cs = 1'b1; wait_clk(8); endtask

    // Master captures miso just before each launch edge, slave samples on the return edge.
    task automatic send_bits(input logic [7:0] d, input int n,
                             output logic [7:0] r1, output logic [7:0] r0);
        r1 = '0; r0 = '0;
        for (int i = 0; i < n; i++) begin
            r1[i] = miso1; r0[i] = miso0;
            mosi = d[i]; scl = 1'b1;
            wait_clk(HALF);
            scl = 1'b0;
            wait_clk(HALF);
        end
    endtask

    task automatic expect_rx(input logic [7:0] d);
        exp_q1.push_back(d);
        exp_q0.push_back(d);
    endtask

    task automatic frame(input logic [7:0] d, input logic [7:0] exp_tx, input string name);
        cs_low();
        expect_rx(d);
        send_bits(d, 8, got1, got0);
        cs_high();
        check({name, "_miso1"}, got1, exp_tx);
        check({name, "_miso0"}, got0, exp_tx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; scl = 1'b0; cs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
`ifdef SPI_SLAVE_OVR_EN
        rx_ack = 1'b0;
`endif
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check("reset_miso", {7'b0, miso1}, 8'h00);
        check("reset_rx_data", rx_data1, 8'h00);
        check("reset_rx_valid", {7'b0, rx_valid1}, 8'h00);
        check("reset_busy", {7'b0, busy1}, 8'h00);
        wait_clk(4);

        // Single frame
        load_tx(8'h3C);
        frame(8'hA5, 8'h3C, "single");

        // Back-to-back under one cs-low; new holding value goes to frame 2
        cs_low();
        check("busy_in_frame", {7'b0, busy1}, 8'h01);
        load_tx(8'h55);
        expect_rx(8'h01);
        send_bits(8'h01, 8, got1, got0);
        check("b2b1_miso1", got1, 8'h3C);
        check("b2b1_miso0", got0, 8'h3C);
        expect_rx(8'hFE);
        send_bits(8'hFE, 8, got1, got0);
        check("b2b2_miso1", got1, 8'h55);
        check("b2b2_miso0", got0, 8'h55);
        cs_high();

        // Abort after 4 bits: partial byte discarded
        cs_low();
        send_bits(8'hFF, 4, got1, got0);
        cs_high();
        check("abort_rx_data", rx_data1, 8'hFE);
        check("abort_miso", {7'b0, miso1}, 8'h00);
        check("abort_busy", {7'b0, busy1}, 8'h00);
        frame(8'h81, 8'h55, "after_abort");

        // Reset after 5 bits, master keeps clocking the rest of that frame
        cs_low();
        send_bits(8'hAA, 5, got1, got0);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_rx_data", rx_data1, 8'h00);
        check("rst_mid_rx_valid", {7'b0, rx_valid1}, 8'h00);
        check("rst_mid_miso", {7'b0, miso1}, 8'h00);
        check("rst_mid_busy", {7'b0, busy1}, 8'h00);
        check("rst_mid_rx_data0", rx_data0, 8'h00);
        rst = 1'b0;
        send_bits(8'h05, 3, got1, got0);
        check("rst_tail_miso1", got1, 8'h00);
        check("rst_tail_miso0", got0, 8'h00);
        cs_high();
        frame(8'h0F, 8'h00, "after_reset");

        // Dedicated pattern for the TRIG=0 instance (shared with TRIG=1)
        load_tx(8'hE7);
        frame(8'hC3, 8'hE7, "trig0");
        check("trig0_rx_data", rx_data0, 8'hC3);

`ifdef SPI_SLAVE_OVR_EN
        do_reset();
        wait_clk(4);
        check("ovr_reset", {7'b0, rx_ovr1}, 8'h00);
        frame(8'h11, 8'h00, "ovr_f1");
        check("ovr_after_f1", {7'b0, rx_ovr1}, 8'h00);
        frame(8'h22, 8'h00, "ovr_f2");
        check("ovr_after_f2", {7'b0, rx_ovr1}, 8'h01);
        check("ovr_after_f2_t0", {7'b0, rx_ovr0}, 8'h01);
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
        frame(8'h33, 8'h00, "ovr_f3");
        check("ovr_sticky", {7'b0, rx_ovr1}, 8'h01);
        check("ovr_rx_data", rx_data1, 8'h33);
        do_reset();
        wait_clk(1);
        check("ovr_cleared", {7'b0, rx_ovr1}, 8'h00);
`endif

        wait_clk(10);
        check("rx1_missing", 8'(exp_q1.size()), 8'h00);
        check("rx0_missing", 8'(exp_q0.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
